// File: rtl/btn_debounce_repeat.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce_repeat
// Purpose  : Synchronise and debounce a push-button; emit one increment pulse
//            per press plus optional auto-repeat pulses while held.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce_repeat #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic en,
    output logic pulse_out,
    output logic btn_level,
    output logic repeating
);

    // A delay or period of 1 would put pulses on back-to-back cycles; 2 is the floor.
    localparam int c_delay_eff  = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
    localparam int c_period_eff = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
    localparam int c_max_a      = (DEBOUNCE_CYCLES > c_delay_eff) ? DEBOUNCE_CYCLES : c_delay_eff;
    localparam int c_cnt_max    = (c_max_a > c_period_eff) ? c_max_a : c_period_eff;
    localparam int c_cnt_w      = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_deb_last    = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_delay_last  = c_cnt_w'(c_delay_eff - 1);
    localparam logic [c_cnt_w-1:0] c_period_last = c_cnt_w'(c_period_eff - 1);
    localparam logic [c_cnt_w-1:0] c_one         = c_cnt_w'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS_CHK = 3'd1,
        ST_HELD      = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_REL_CHK   = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic                   w_fire;
    logic                   r_pulse;
    logic                   r_level;
    logic                   r_repeating;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pulse     <= 1'b0;
            r_level     <= 1'b0;
            r_repeating <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pulse     <= w_fire & en;
            r_level     <= (w_state_nxt == ST_HELD) || (w_state_nxt == ST_REPEAT) ||
                           (w_state_nxt == ST_REL_CHK);
            r_repeating <= (w_state_nxt == ST_REPEAT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = ST_HELD;
                        w_fire      = 1'b1;
                    end else begin
                        w_state_nxt = ST_PRESS_CHK;
                        w_cnt_nxt   = c_one;
                    end
                end
            end
            ST_PRESS_CHK: begin
                if (!w_btn_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_deb_last) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_fire      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            ST_HELD, ST_REPEAT: begin
                if (!w_btn_s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_REL_CHK;
                        w_cnt_nxt   = c_one;
                    end
                end else if (r_state == ST_REPEAT) begin
                    if (r_cnt >= c_period_last) begin
                        w_cnt_nxt = '0;
                        w_fire    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_one;
                    end
                end else if ((REPEAT_EN != 0) && (r_cnt >= c_delay_last)) begin
                    w_state_nxt = ST_REPEAT;
                    w_cnt_nxt   = '0;
                    w_fire      = 1'b1;
                end else if (r_cnt != '1) begin
                    // Saturates when auto-repeat is off and the button is held indefinitely.
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            ST_REL_CHK: begin
                if (w_btn_s) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= c_deb_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign pulse_out = r_pulse;
    assign btn_level = r_level;
    assign repeating = r_repeating;

endmodule
`default_nettype wire
